// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper, its controller and the 3-input function unit.
// The slave side is the sweeper; the master side is the controller/unit.
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [2:0] drv_abc;
  logic       sample_o;
  logic       busy;
  logic       done;
  logic [7:0] table_o;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] mismatch_idx;

  modport master (
    output start, abort, sample_o,
    input  drv_abc, busy, done, table_o,
    input  pass, err_count, mismatch_idx
  );

  modport slave (
    input  start, abort, sample_o,
    output drv_abc, busy, done, table_o,
    output pass, err_count, mismatch_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives all eight {A,B,C} vectors, captures the unit output after a
// settle delay and grades the captured truth table against a golden one.
module truth_table_sweeper #(
  parameter int         SETTLE   = 1,
  parameter logic [7:0] EXPECTED = 8'h1A
) (
  input logic                 clk,
  input logic                 rst,
  truth_table_sweeper_if.slave bus
);

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] drv_q, drv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] tab_q, tab_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [2:0] mis_q, mis_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      drv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tab_q   <= '0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tab_q   <= tab_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drv_d   = 3'b000;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    tab_d   = tab_q;
    pass_d  = pass_q;
    err_d   = err_q;
    mis_d   = mis_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (!bus.abort && bus.start) begin
          state_d = S_WAIT;
          idx_d   = '0;
          cnt_d   = SETTLE_W;
          busy_d  = 1'b1;
          tab_d   = '0;
          pass_d  = 1'b0;
          err_d   = '0;
          mis_d   = '0;
        end
      end
      (state_q == S_WAIT): begin
        if (bus.abort) begin
          state_d = S_IDLE;
          tab_d   = '0;
          pass_d  = 1'b0;
          err_d   = '0;
          mis_d   = '0;
        end else begin
          busy_d = 1'b1;
          drv_d  = idx_q;
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            tab_d[idx_q] = bus.sample_o;
            if (bus.sample_o != EXPECTED[idx_q]) begin
              err_d = err_q + 4'd1;
              // err_q still zero means this is the first miss
              if (err_q == 4'd0)
                mis_d = idx_q;
            end
            if (idx_q == 3'd7) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              drv_d   = 3'b000;
              pass_d  = (err_d == 4'd0);
            end else begin
              idx_d = idx_q + 3'd1;
              cnt_d = SETTLE_W;
              drv_d = idx_q + 3'd1;
            end
          end
        end
      end
      (state_q == S_DONE): begin
        state_d = S_IDLE;
        if (bus.abort) begin
          tab_d  = '0;
          pass_d = 1'b0;
          err_d  = '0;
          mis_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.drv_abc      = drv_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.table_o      = tab_q;
  assign bus.pass         = pass_q;
  assign bus.err_count    = err_q;
  assign bus.mismatch_idx = mis_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (SETTLE=1 and SETTLE=0) driven by a
// table-lookup function unit, graded against a truth-table reference.
module tb_truth_table_sweeper;

  localparam logic [7:0] GOLD = 8'h1A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  truth_table_sweeper_if b1 ();
  truth_table_sweeper_if b0 ();

  truth_table_sweeper #(.SETTLE(1), .EXPECTED(GOLD)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  truth_table_sweeper #(.SETTLE(0), .EXPECTED(GOLD)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  logic       sel = 1'b1;
  logic       start_r = 1'b0;
  logic       abort_r = 1'b0;
  logic [7:0] fu_tab = GOLD;

  assign b1.start    = sel & start_r;
  assign b0.start    = ~sel & start_r;
  assign b1.abort    = sel & abort_r;
  assign b0.abort    = ~sel & abort_r;
  assign b1.sample_o = fu_tab[b1.drv_abc];
  assign b0.sample_o = fu_tab[b0.drv_abc];

  wire [2:0] m_drv  = sel ? b1.drv_abc : b0.drv_abc;
  wire       m_busy = sel ? b1.busy : b0.busy;
  wire       m_done = sel ? b1.done : b0.done;
  wire [7:0] m_tab  = sel ? b1.table_o : b0.table_o;
  wire       m_pass = sel ? b1.pass : b0.pass;
  wire [3:0] m_err  = sel ? b1.err_count : b0.err_count;
  wire [2:0] m_mis  = sel ? b1.mismatch_idx : b0.mismatch_idx;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference grading of a truth table against the golden one.
  function automatic logic [3:0] ref_err(input logic [7:0] t);
    return 4'($countones(t ^ GOLD));
  endfunction

  function automatic logic [2:0] ref_mis(input logic [7:0] t);
    logic [7:0] d;
    logic [2:0] m;
    d = t ^ GOLD;
    m = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (d[i]) m = 3'(i);
    return m;
  endfunction

  task automatic run_sweep(input string tag, input logic [7:0] tab);
    int s;
    int lat;
    int cyc;
    bit seq_ok;
    s = sel ? 1 : 0;
    lat = 8 * (s + 1);
    fu_tab = tab;
    @(negedge clk) start_r = 1'b1;
    @(negedge clk) start_r = 1'b0;
    cyc = 1;
    seq_ok = 1'b1;
    while (cyc <= 60 && !m_done) begin
      if (m_drv !== 3'((cyc - 1) / (s + 1)) || m_busy !== 1'b1)
        seq_ok = 1'b0;
      @(negedge clk) cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(lat + 1));
    chk({tag, "_drv_seq"}, 32'(seq_ok), 32'd1);
    chk({tag, "_table"}, 32'(m_tab), 32'(tab));
    chk({tag, "_err"}, 32'(m_err), 32'(ref_err(tab)));
    chk({tag, "_mis"}, 32'(m_mis), 32'(ref_mis(tab)));
    chk({tag, "_pass"}, 32'(m_pass), 32'(tab == GOLD));
    chk({tag, "_busy_done"}, 32'(m_busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(m_done), 32'd0);
    chk({tag, "_hold"}, 32'({m_tab, m_pass}), 32'({tab, tab == GOLD}));
  endtask

  initial begin
    int cyc;
    int dones;
    bit clash;
    logic [7:0] rt;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs",
        32'({b1.drv_abc, b1.busy, b1.done, b1.table_o,
             b1.pass, b1.err_count, b1.mismatch_idx}), 32'd0);

    sel = 1'b1;
    run_sweep("good_s1", GOLD);
    run_sweep("stuck0_s1", 8'h00);
    chk("stuck0_err3", 32'(m_err), 32'd3);
    chk("stuck0_mis1", 32'(m_mis), 32'd1);

    sel = 1'b0;
    run_sweep("inv_s0", ~GOLD);
    chk("inv_tab_e5", 32'(m_tab), 32'hE5);
    chk("inv_err8", 32'(m_err), 32'd8);
    sel = 1'b1;

    // start held high across a whole sweep and beyond
    fu_tab = GOLD;
    @(negedge clk) start_r = 1'b1;
    @(negedge clk);
    dones = 0;
    clash = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (m_done) dones++;
      if (m_done && m_busy) clash = 1'b1;
      if (c == 18) chk("hold_idle_gap", 32'(m_busy), 32'd0);
      @(negedge clk);
    end
    chk("hold_one_done", 32'(dones), 32'd1);
    chk("hold_no_clash", 32'(clash), 32'd0);
    chk("hold_restart", 32'(m_busy), 32'd1);
    start_r = 1'b0;
    cyc = 0;
    while (cyc < 60 && !m_done) begin
      @(negedge clk) cyc++;
    end
    chk("hold_second_pass", 32'({m_done, m_pass}), 32'b11);
    @(negedge clk);

    // abort while idx=4, after a mismatch has been recorded
    fu_tab = 8'h00;
    @(negedge clk) start_r = 1'b1;
    @(negedge clk) start_r = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_at_idx4", 32'(m_drv), 32'd4);
    abort_r = 1'b1;
    @(negedge clk) abort_r = 1'b0;
    chk("abort_cleared",
        32'({m_busy, m_drv, m_tab, m_pass, m_err, m_mis}), 32'd0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_sweep("after_abort", GOLD);

    // abort and start together in IDLE: abort wins
    start_r = 1'b1;
    abort_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    abort_r = 1'b0;
    chk("abort_beats_start", 32'(m_busy), 32'd0);
    @(negedge clk);

    // synchronous reset while idx=5
    fu_tab = 8'h00;
    @(negedge clk) start_r = 1'b1;
    @(negedge clk) start_r = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_at_idx5", 32'(m_drv), 32'd5);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rst_mid_sweep",
        32'({m_busy, m_done, m_drv, m_tab, m_pass, m_err, m_mis}), 32'd0);
    run_sweep("after_rst", GOLD);

    for (int r = 0; r < 5; r++) begin
      rt = 8'($urandom);
      sel = (r % 2) == 0;
      run_sweep($sformatf("rand%0d", r), rt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
